mem_arbiter: RTL

- Shares the single unified instruction/data memory of the multicycle core between two requesters: the core's fetch/load/store path and an external port (DMA/debug loader).
- Read is combinational and write is synchronous, so each granted access completes in one cycle.
- The core is held off with CoreStall, and its main FSM freezes while CoreStall=1.
- Fairness is round-robin, plus an external locked-burst mode bounded by BURST_MAX.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr2_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified-memory arbiter
//
// Purpose: FSM state encoding and owner identifiers used by mem_arbiter
//          and rr2_pick.
// Contents:
//   arb_state_e : ARB (normal round-robin) / LOCK (external locked burst)
//   OWN_CORE    : owner id of the core requester (req/gnt bit 0)
//   OWN_EXT     : owner id of the external requester (req/gnt bit 1)
package mem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_EXT  = 1'b1;

endpackage

// File: rtl/rr2_pick.sv
// rtl/rr2_pick.sv - combinational two-way round-robin picker
//
// Purpose: grants one of two requesters. A lone requester always wins.
//          On contention the requester that did not own the previous
//          grant wins.
// Ports:
//   req[1:0]   in  : request vector, bit 0 = core, bit 1 = external
//   last_owner in  : owner of the most recent grant (OWN_CORE / OWN_EXT)
//   gnt[1:0]   out : one-hot grant (all zero when nothing requests)
module rr2_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == OWN_EXT) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core/external arbiter for a single unified memory
//
// Purpose: shares one combinational-read, synchronous-write memory between
//          the core (fetch/load/store) and an external DMA/debug port.
//          Round-robin fairness, plus locked external bursts of at most
//          BURST_MAX consecutive grants. Every grant completes in the cycle
//          it is given.
// Parameters: AW address width, DW data width, BURST_MAX locked burst
//             length (>=1), CW stall counter width.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   CoreReq/We/Adr/WD          : core request, write flag, address, data
//   CoreRD, CoreStall          : core read data, core must hold its state
//   ExtReq/We/Lock/Adr/WD      : external request (held until ExtAck),
//                                write flag, burst lock, address, data
//   ExtRD, ExtAck              : external read data, access performed
//   MemAdr/MemWE/MemWD, MemRD  : memory port
//   StallCnt                   : saturating count of CoreStall cycles
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CoreReq,
  input  logic          CoreWe,
  input  logic [AW-1:0] CoreAdr,
  input  logic [DW-1:0] CoreWD,
  output logic [DW-1:0] CoreRD,
  output logic          CoreStall,
  input  logic          ExtReq,
  input  logic          ExtWe,
  input  logic          ExtLock,
  input  logic [AW-1:0] ExtAdr,
  input  logic [DW-1:0] ExtWD,
  output logic [DW-1:0] ExtRD,
  output logic          ExtAck,
  output logic [AW-1:0] MemAdr,
  output logic          MemWE,
  output logic [DW-1:0] MemWD,
  input  logic [DW-1:0] MemRD,
  output logic [CW-1:0] StallCnt
);

  // Holds the remaining grants of a burst; BURST_MAX-1 must fit.
  localparam int LCW     = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam bit LOCK_EN = (BURST_MAX > 1);

  arb_state_e     state;
  logic           last_owner;
  logic [LCW-1:0] lock_cnt;

  logic [1:0] rr_gnt;
  logic       lock_hold;
  logic       gnt_core;
  logic       gnt_ext;

  rr2_pick u_rr2_pick (
    .req        ({ExtReq, CoreReq}),
    .last_owner (last_owner),
    .gnt        (rr_gnt)
  );

  // A burst continues only while the external side keeps both request and
  // lock high; otherwise this cycle is arbitrated by the ordinary rules.
  assign lock_hold = (state == LOCK) && ExtReq && ExtLock;

  always_comb begin
    gnt_core = 1'b0;
    gnt_ext  = 1'b0;
    if (!reset) begin
      if (lock_hold) begin
        gnt_ext = 1'b1;
      end else begin
        gnt_core = rr_gnt[0];
        gnt_ext  = rr_gnt[1];
      end
    end
  end

  // Datapath: the external port owns the memory only when granted; the
  // core's write enable is qualified so a stalled core cannot write.
  always_comb begin
    if (gnt_ext) begin
      MemAdr = ExtAdr;
      MemWD  = ExtWD;
      MemWE  = ExtWe;
    end else begin
      MemAdr = CoreAdr;
      MemWD  = CoreWD;
      MemWE  = CoreWe & gnt_core;
    end
  end

  assign CoreRD    = MemRD;
  assign ExtRD     = MemRD;
  assign ExtAck    = gnt_ext;
  assign CoreStall = CoreReq & ~gnt_core & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      last_owner <= OWN_EXT;
      lock_cnt   <= '0;
      StallCnt   <= '0;
    end else begin
      if (gnt_core) begin
        last_owner <= OWN_CORE;
      end else if (gnt_ext) begin
        last_owner <= OWN_EXT;
      end

      if (lock_hold) begin
        lock_cnt <= lock_cnt - LCW'(1);
        if (lock_cnt == LCW'(1)) begin
          state <= ARB;
        end
      end else if (LOCK_EN && gnt_ext && ExtLock) begin
        // The grant of this cycle is the first of the burst.
        state    <= LOCK;
        lock_cnt <= LCW'(BURST_MAX - 1);
      end else begin
        state    <= ARB;
        lock_cnt <= '0;
      end

      if (CoreStall && (StallCnt != {CW{1'b1}})) begin
        StallCnt <= StallCnt + CW'(1);
      end
    end
  end

endmodule
